// File: rtl/vedic_pkg.sv
// Shared defaults and the accumulator FSM state type for the Vedic MAC stage.
package vedic_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } acc_state_t;

endpackage : vedic_pkg

// File: rtl/vedic_mult.sv
// Unsigned WIDTH x WIDTH multiplier built from the vertical-and-crosswise
// (Urdhva-Tiryagbhyam) column sums: column k collects every a[i]*b[k-i]
// partial-product bit, and the columns are then weighted by 2^k and summed.
module vedic_mult #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  // Column sums of the crosswise partial products, then weighted accumulation.
  always_comb begin
    logic [2*WIDTH-1:0] row;
    logic [2*WIDTH-1:0] col;
    logic [2*WIDTH-1:0] bit_sel;
    product = '0;
    row     = '0;
    col     = '0;
    bit_sel = '0;
    for (int k = 0; k < 2*WIDTH-1; k++) begin
      col = '0;
      for (int i = 0; i < WIDTH; i++) begin
        // Row i is b gated by a[i], shifted into place; its bit k is a[i]&b[k-i].
        row     = {{WIDTH{1'b0}}, (b & {WIDTH{a[i]}})} << i;
        bit_sel = row >> k;
        col     = col + {{(2*WIDTH-1){1'b0}}, bit_sel[0]};
      end
      product = product + (col << k);
    end
  end

endmodule : vedic_mult

// File: rtl/vedic_mac_stage.sv
// Pipelined multiply-accumulate stage: S1 operand register, S2 product
// register, then an accumulator that emits one result per dot product.
// state | meaning
// EMPTY | no beats accumulated since the last result was emitted
// RUN   | a dot product is partially accumulated
module vedic_mac_stage
  import vedic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  // The whole pipeline stalls only while a result is waiting on the consumer.
  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  logic             s1_valid, s1_last;
  logic [WIDTH-1:0] s1_a, s1_b;

  // S1: capture the offered beat, or a bubble when nothing is offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_last  <= in_last;
      s1_a     <= in_a;
      s1_b     <= in_b;
    end
  end

  logic [2*WIDTH-1:0] prod;

  vedic_mult #(.WIDTH(WIDTH)) u_mult (
    .a       (s1_a),
    .b       (s1_b),
    .product (prod)
  );

  logic               s2_valid, s2_last;
  logic [2*WIDTH-1:0] s2_prod;

  // S2: register the product alongside its control bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_prod  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_prod  <= prod;
    end
  end

  acc_state_t       state, state_next;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             beat;

  assign beat = adv && s2_valid;

  // Accumulator FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  logic [ACC_W-1:0] acc_base;
  logic [CNT_W-1:0] cnt_base;
  logic             ovf_base;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  // Next-state and running-sum update; EMPTY always starts from a zero base.
  always_comb begin
    state_next = state;
    acc_base   = acc;
    cnt_base   = cnt;
    ovf_base   = ovf;
    if (state == EMPTY) begin
      acc_base = '0;
      cnt_base = '0;
      ovf_base = 1'b0;
    end
    sum      = {1'b0, acc_base} + {{(ACC_W+1-2*WIDTH){1'b0}}, s2_prod};
    acc_next = sum[ACC_W-1:0];
    cnt_next = (cnt_base == {CNT_W{1'b1}}) ? cnt_base : cnt_base + 1'b1;
    ovf_next = ovf_base | sum[ACC_W];
    if (beat) begin
      state_next = s2_last ? EMPTY : RUN;
    end
  end

  // Running sum: fold in each valid beat, clear when the dot product closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (beat) begin
      if (s2_last) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= acc_next;
        cnt <= cnt_next;
        ovf <= ovf_next;
      end
    end
  end

  // Result register: load on a closing beat, hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_acc      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else if (adv) begin
      out_valid <= beat && s2_last;
      if (beat && s2_last) begin
        out_acc      <= acc_next;
        out_count    <= cnt_next;
        out_overflow <= ovf_next;
      end
    end
  end

endmodule : vedic_mac_stage

// File: tb/tb_vedic_mac_stage.sv
// Scoreboard bench for vedic_mac_stage: a default instance (ACC_W=24) and a
// narrow-accumulator instance (ACC_W=17) share operands and out_ready.
module tb_vedic_mac_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  in_a, in_b;
  logic        in_last, out_ready, v8, v17;
  logic        rdy8, ov8, ovf8, rdy17, ov17, ovf17;
  logic [23:0] acc8;
  logic [16:0] acc17;
  logic [7:0]  cnt8, cnt17;

  vedic_mac_stage #(.WIDTH(8), .ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(ov8), .out_ready(out_ready),
    .out_acc(acc8), .out_count(cnt8), .out_overflow(ovf8)
  );

  vedic_mac_stage #(.WIDTH(8), .ACC_W(17), .CNT_W(8)) dut17 (
    .clk(clk), .rst_n(rst_n), .in_valid(v17), .in_ready(rdy17),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(ov17), .out_ready(out_ready),
    .out_acc(acc17), .out_count(cnt17), .out_overflow(ovf17)
  );

  typedef struct {
    logic [31:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q17[$];
  int   hs8[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int acc, input int cnt, input logic ovf);
    exp_t e;
    e.acc = acc;
    e.cnt = cnt[7:0];
    e.ovf = ovf;
    return e;
  endfunction

  // Monitor: a handshake happens at the next rising edge; compare against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov8 && out_ready) begin
      hs8.push_back(cyc);
      if (q8.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected8: got result acc=%0d expected none", acc8);
      end else begin
        e = q8.pop_front();
        check("acc8", acc8, e.acc);
        check("cnt8", cnt8, e.cnt);
        check("ovf8", ovf8, e.ovf);
      end
    end
    if (rst_n && ov17 && out_ready) begin
      if (q17.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected17: got result acc=%0d expected none", acc17);
      end else begin
        e = q17.pop_front();
        check("acc17", acc17, e.acc);
        check("cnt17", cnt17, e.cnt);
        check("ovf17", ovf17, e.ovf);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge, valid still high.
  task automatic send(input int sel, input int a, input int b, input logic last);
    int n;
    in_a = a[7:0]; in_b = b[7:0]; in_last = last;
    if (sel == 0) begin v8 = 1'b1; v17 = 1'b0; end
    else          begin v8 = 1'b0; v17 = 1'b1; end
    n = 0;
    #1;
    while (!((sel == 0) ? rdy8 : rdy17) && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 50) begin
      checks++; fails++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected 1", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    v8 = 1'b0; v17 = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q8.size() != 0 || q17.size() != 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q8.size() != 0 || q17.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", q8.size(), q17.size());
    end
  endtask

  initial begin
    int n;
    logic [23:0] held_acc;
    rst_n = 1'b0; v8 = 1'b0; v17 = 1'b0;
    in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_ready", rdy8, 1);
    check("rst_valid", ov8, 0);
    check("rst_acc", acc8, 0);
    check("rst_cnt", cnt8, 0);
    check("rst_ovf", ovf8, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rel_ready", rdy8, 1);

    // Single 255*255 beat and its fixed latency.
    q8.push_back(mk(65025, 1, 1'b0));
    send(0, 255, 255, 1'b1);
    idle();
    check("lat_e1", ov8, 0);
    @(posedge clk); #1;
    check("lat_e2", ov8, 0);
    @(posedge clk); #1;
    check("lat_e3", ov8, 1);
    drain();

    // Four-beat dot product followed immediately by a one-beat product.
    hs8.delete();
    q8.push_back(mk(100, 4, 1'b0));
    q8.push_back(mk(6, 1, 1'b0));
    send(0, 1, 2, 1'b0);
    send(0, 3, 4, 1'b0);
    send(0, 5, 6, 1'b0);
    send(0, 7, 8, 1'b1);
    send(0, 2, 3, 1'b1);
    idle();
    drain();
    check("b2b_results", hs8.size(), 2);
    if (hs8.size() == 2) check("b2b_gap", hs8[1] - hs8[0], 1);

    // Backpressure: result pending, new beat offered, outputs must hold.
    out_ready = 1'b0;
    q8.push_back(mk(20, 1, 1'b0));
    send(0, 4, 5, 1'b1);
    idle();
    n = 0;
    while (!ov8 && n < 10) begin @(posedge clk); #1; n++; end
    check("bp_valid", ov8, 1);
    held_acc = acc8;
    in_a = 8'd1; in_b = 8'd1; in_last = 1'b1; v8 = 1'b1;
    q8.push_back(mk(1, 1, 1'b0));
    #1;
    check("bp_ready", rdy8, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_hold_acc", acc8, 20);
      check("bp_hold_cnt", cnt8, 1);
      check("bp_ready_low", rdy8, 0);
    end
    check("bp_stable", acc8, held_acc);
    out_ready = 1'b1;
    @(posedge clk); #1;
    idle();
    drain();
    repeat (4) @(posedge clk);
    #1;
    check("bp_no_dup", ov8, 0);

    // Narrow accumulator wraps and flags overflow, then restarts clean.
    q17.push_back(mk(64003, 3, 1'b1));
    q17.push_back(mk(1, 1, 1'b0));
    send(1, 255, 255, 1'b0);
    send(1, 255, 255, 1'b0);
    send(1, 255, 255, 1'b1);
    send(1, 1, 1, 1'b1);
    idle();
    drain();

    // Beat counter saturates while the sum keeps growing.
    q8.push_back(mk(300, 255, 1'b0));
    for (int i = 0; i < 299; i++) send(0, 1, 1, 1'b0);
    send(0, 1, 1, 1'b1);
    idle();
    drain();

    // Reset with a partial sum and beats in flight discards everything.
    send(0, 1, 2, 1'b0);
    send(0, 3, 4, 1'b0);
    send(0, 5, 6, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", ov8, 0);
    check("mid_rst_acc", acc8, 0);
    check("mid_rst_cnt", cnt8, 0);
    check("mid_rst_ovf", ovf8, 0);
    check("mid_rst_ready", rdy8, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q8.push_back(mk(6, 1, 1'b0));
    send(0, 2, 3, 1'b1);
    idle();
    drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_vedic_mac_stage
